rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream resource (single-port memory, shared ALU) among N requesters.
- Registers a one-hot grant and its binary index. The index is encoded with the library's one-hot-to-binary encoder.
- Sequences each transaction with a three-state FSM: pick → offer to resource → wait for completion.
- Rotating priority pointer advances only after completion, so every requester gets service.

---
 rtl/rr_arb_pkg.sv | 21 ++
 rtl/onehot_to_bin.sv | 23 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_onehot_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
//   - arb_state_e      : transaction FSM states
//   - DefNReq          : default requester count
//   - DefTimeoutCycles : default watchdog limit (used only with ARB_TIMEOUT_EN)
//   - idx_width()      : width of a binary index into N items (minimum 1)
package rr_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StBusy  = 2'd2
    } arb_state_e;

    localparam int unsigned DefNReq          = 4;
    localparam int unsigned DefTimeoutCycles = 64;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder. An all-zero input encodes to 0.
//   oh_i  in  N      one-hot vector
//   bin_o out IDX_W  index of the set bit
module onehot_to_bin
    import rr_arb_pkg::*;
#(
    parameter int unsigned N     = DefNReq,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     oh_i,
    output logic [IDX_W-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < N; i++) begin
            if (oh_i[i]) begin
                bin_o = bin_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick.
// Returns the first set bit of req_i searching upward from ptr_i and wrapping
// from N_REQ-1 to 0. The result is one-hot, or zero when req_i is zero.
//   req_i  in  N_REQ  request vector
//   ptr_i  in  IDX_W  highest-priority index (must be < N_REQ)
//   pick_o out N_REQ  one-hot pick
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk the ring starting at ptr; explicit wrap compare keeps this
    // correct for non-power-of-2 N_REQ.
    always_comb begin
        pick_o  = '0;
        w_found = 1'b0;
        w_idx   = ptr_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req_i[w_idx]) begin
                pick_o[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
            w_idx = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter sharing one downstream resource among N_REQ requesters.
// Each transaction runs IDLE -> GRANT (offer) -> BUSY (wait for done) -> IDLE.
// The priority pointer moves past the served requester only on completion.
// Optional watchdog: define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES.
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   req_i        in   request per requester
//   gnt_o        out  registered one-hot grant, zero when idle
//   gnt_idx_o    out  binary index of gnt_o, zero when idle
//   gnt_valid_o  out  offer to resource (GRANT state)
//   gnt_ready_i  in   resource accepts the offer
//   done_i       in   resource finished (sampled in BUSY only)
//   busy_o       out  high in GRANT or BUSY
//   timeout_o    out  one-cycle watchdog abort pulse (0 without ARB_TIMEOUT_EN)
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = DefNReq,
    parameter int unsigned IDX_W          = idx_width(N_REQ),
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    input  logic             gnt_ready_i,
    input  logic             done_i,
    output logic             busy_o,
    output logic             timeout_o
);

    if (N_REQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rr_onehot_arbiter: N_REQ and TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_e       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0] w_ptr_adv;
    logic [N_REQ-1:0] w_pick;
    logic [IDX_W-1:0] w_pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (r_ptr),
        .pick_o (w_pick)
    );

    onehot_to_bin #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .oh_i  (w_pick),
        .bin_o (w_pick_idx)
    );

    // Pointer moves to the requester after the one just served.
    assign w_ptr_adv = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (|req_i) begin
                    w_state_nxt = StGrant;
                    w_gnt_nxt   = w_pick;
                    w_idx_nxt   = w_pick_idx;
                end
            end
            StGrant: begin
                // Accept beats a simultaneous withdrawal.
                if (gnt_ready_i) begin
                    w_state_nxt = StBusy;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end else if ((req_i & r_gnt) == '0) begin
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            StBusy: begin
                if (done_i) begin
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ptr_nxt   = w_ptr_adv;
                end
`ifdef ARB_TIMEOUT_EN
                // Counter holds the number of earlier BUSY cycles, so this
                // fires at the end of the TIMEOUT_CYCLES-th cycle without done.
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt   = StIdle;
                    w_gnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_ptr_nxt     = w_ptr_adv;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_idx;
    assign gnt_valid_o = (r_state == StGrant);
    assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed self-checking bench for rr_onehot_arbiter (N_REQ=4, TIMEOUT_CYCLES=8).
module tb_rr_onehot_arbiter;

    localparam int unsigned NReq = 4;
    localparam int unsigned IdxW = 2;
    localparam int unsigned Tmo  = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NReq-1:0] req_i;
    logic [NReq-1:0] gnt_o;
    logic [IdxW-1:0] gnt_idx_o;
    logic            gnt_valid_o;
    logic            gnt_ready_i;
    logic            done_i;
    logic            busy_o;
    logic            timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    rr_onehot_arbiter #(
        .N_REQ          (NReq),
        .IDX_W          (IdxW),
        .TIMEOUT_CYCLES (Tmo)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_ready_i (gnt_ready_i),
        .done_i      (done_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock edge; outputs are stable 1ns later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Check the full visible state: grant vector, index, valid, busy, timeout.
    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic v, input logic b, input logic t);
        check_eq({tag, ".gnt"},   32'(gnt_o),       32'(g));
        check_eq({tag, ".idx"},   32'(gnt_idx_o),   32'(idx));
        check_eq({tag, ".valid"}, 32'(gnt_valid_o), 32'(v));
        check_eq({tag, ".busy"},  32'(busy_o),      32'(b));
        check_eq({tag, ".tmo"},   32'(timeout_o),   32'(t));
    endtask

    // From GRANT: accept, one BUSY cycle without done, then done -> IDLE.
    task automatic serve(input string tag, input logic [3:0] g, input logic [1:0] idx);
        gnt_ready_i = 1'b1;
        step();
        check_out({tag, ".busy"}, g, idx, 1'b0, 1'b1, 1'b0);
        gnt_ready_i = 1'b0;
        step();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check_out({tag, ".idle"}, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [1:0] exp_i [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset wins over pending requests.
        rst_i       = 1'b1;
        req_i       = 4'b1111;
        gnt_ready_i = 1'b0;
        done_i      = 1'b0;
        step();
        step();
        check_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        step();
        check_out("first", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        // Fair rotation with all requesters active.
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("rr%0d", k), exp_g[k], exp_i[k], 1'b1, 1'b1, 1'b0);
            serve($sformatf("rr%0d", k), exp_g[k], exp_i[k]);
            if (k < 4) step();
        end
        // ptr=1 now. Grant idx 2 so ptr becomes 3, then wrap to idx 0.
        req_i = 4'b0100;
        step();
        check_out("g2", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        serve("g2", 4'b0100, 2'd2);
        req_i = 4'b0001;
        step();
        check_out("wrap", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        serve("wrap", 4'b0001, 2'd0);

        // ptr=1: full request picks idx 1, then withdraw it.
        req_i = 4'b1111;
        step();
        check_out("g1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        req_i = 4'b1101;
        step();
        check_out("wdraw", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        req_i = 4'b1111;
        step();
        check_out("regrant", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);

        // ready and done together in GRANT: only moves to BUSY.
        gnt_ready_i = 1'b1;
        done_i      = 1'b1;
        step();
        check_out("rdydone", 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
        gnt_ready_i = 1'b0;
        done_i      = 1'b0;
        step();
        check_out("hold", 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check_out("done2", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // ptr=2: grant idx 2, accept, never complete.
        req_i = 4'b0100;
        step();
        check_out("t_g2", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        gnt_ready_i = 1'b1;
        step();
        gnt_ready_i = 1'b0;
        for (int c = 1; c < Tmo; c++) begin
            check_out($sformatf("t_busy%0d", c), 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
            step();
        end
        check_out("t_busy8", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        step();
`ifdef ARB_TIMEOUT_EN
        check_out("t_abort", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
`else
        check_out("t_stay", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        step();
        check_out("t_stay2", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check_out("t_done", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
`endif
        req_i = 4'b1111;
        step();
        check_out("t_next", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
